// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported instruction/data RAM between the IF (read-only) and MEM (read/write) stages.
// One access in flight at a time; MEM has priority unless IF has waited through STARVE_LIMIT MEM grants.
module unified_mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ack,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_ack,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  stall_if,
    output logic                  stall_mem,
    output logic                  busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic [3:0] LAT_LOAD = 4'(MEM_LATENCY - 1);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic [1:0]            r_state;
    logic                  r_grant_if;
    logic                  r_we;
    logic [3:0]            r_wait_cnt;
    logic [3:0]            r_starve_cnt;
    logic                  r_if_ack;
    logic                  r_mem_ack;
    logic [DATA_WIDTH-1:0] r_if_rdata;
    logic [DATA_WIDTH-1:0] r_mem_rdata;
    logic                  r_ram_en;
    logic                  r_ram_we;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic [DATA_WIDTH-1:0] r_ram_wdata;

    logic                  w_pick_if;

    // IF goes first when MEM is absent or when IF has been starved long enough
    assign w_pick_if = if_req & (~mem_req | (r_starve_cnt == STARVE_MAX));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_grant_if   <= 1'b0;
            r_we         <= 1'b0;
            r_wait_cnt   <= '0;
            r_starve_cnt <= '0;
            r_if_ack     <= 1'b0;
            r_mem_ack    <= 1'b0;
            r_if_rdata   <= '0;
            r_mem_rdata  <= '0;
            r_ram_en     <= 1'b0;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_wdata  <= '0;
        end else begin
            r_if_ack  <= 1'b0;
            r_mem_ack <= 1'b0;
            r_ram_en  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pick_if) begin
                        r_grant_if   <= 1'b1;
                        r_we         <= 1'b0;
                        r_ram_en     <= 1'b1;
                        r_ram_we     <= 1'b0;
                        r_ram_addr   <= if_addr;
                        r_ram_wdata  <= '0;
                        r_starve_cnt <= '0;
                        r_state      <= S_ACCESS;
                    end else if (mem_req) begin
                        r_grant_if  <= 1'b0;
                        r_we        <= mem_we;
                        r_ram_en    <= 1'b1;
                        r_ram_we    <= mem_we;
                        r_ram_addr  <= mem_addr;
                        r_ram_wdata <= mem_wdata;
                        if (!if_req)
                            r_starve_cnt <= '0;
                        else if (r_starve_cnt != STARVE_MAX)
                            r_starve_cnt <= r_starve_cnt + 4'd1;
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_ram_we <= 1'b0;
                    if (r_we) begin
                        r_mem_ack <= 1'b1;
                        r_state   <= S_RESP;
                    end else begin
                        r_wait_cnt <= LAT_LOAD;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_wait_cnt == '0) begin
                        if (r_grant_if) begin
                            r_if_rdata <= ram_rdata;
                            r_if_ack   <= 1'b1;
                        end else begin
                            r_mem_rdata <= ram_rdata;
                            r_mem_ack   <= 1'b1;
                        end
                        r_state <= S_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign if_ack    = r_if_ack;
    assign if_rdata  = r_if_rdata;
    assign mem_ack   = r_mem_ack;
    assign mem_rdata = r_mem_rdata;
    assign ram_en    = r_ram_en;
    assign ram_we    = r_ram_we;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign stall_if  = if_req & ~r_if_ack;
    assign stall_mem = mem_req & ~r_mem_ack;
    assign busy      = (r_state != S_IDLE);

endmodule
